axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 23 ++
 rtl/axi_rd_arbiter_tag_fifo.sv | 65 ++++++
 rtl/axi_rd_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter.
//   AXI_SIZE_8B / AXI_BURST_INCR : fixed AR attributes (8-byte beats, INCR bursts)
//   ARID_W / LEN_W               : AXI ID and burst-length field widths
//   tag_width()                  : width of a requester index (tag) for a given requester count
//   ar_state_t                   : AR issue machine states
package axi_rd_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;

  localparam int ARID_W = 6;
  localparam int LEN_W  = 4;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_tag_fifo.sv
// arb_tag_fifo: small synchronous FIFO holding per-burst bookkeeping in AR order.
//   m_axi_clk, m_axi_rst : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data      : write one entry (accepted when not full, or when full and popping)
//   pop                  : drop the head entry (ignored when empty)
//   head                 : current head entry, valid only while !empty
//   empty, full          : occupancy flags
module arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             m_axi_clk,
  input  logic             m_axi_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge m_axi_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter funnelling NUM_REQ burst requesters onto one
// AXI read master, routing R beats back to the owner in AR order.
//   m_axi_clk, m_axi_rst          : clock, asynchronous active-high reset
//   req_valid/req_addr/req_len    : per-requester burst request (addr 8-byte aligned, len = beats-1)
//   req_ready                     : one-hot pulse when a request is latched
//   rsp_valid/rsp_data/rsp_last   : beat strobe to the owning requester, shared data/last
//   rsp_ready                     : per-requester beat acceptance
//   m_axi_ar*                     : AXI read address channel (master side)
//   m_axi_r*                      : AXI read data channel (master side)
//   err_overrun                   : sticky protocol error (stray beat or misplaced rlast)
//
// AR issue machine:
//   state    | meaning
//   AR_IDLE  | waiting for an eligible request with room in the tag FIFO; latches the winner
//   AR_ISSUE | arvalid held with stable fields until arready; tag pushed on handshake
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int OUTSTANDING = 8
) (
  input  logic                  m_axi_clk,
  input  logic                  m_axi_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]  req_len,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  rsp_last,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [31:0]           m_axi_araddr,
  output logic [3:0]            m_axi_arlen,
  output logic [5:0]            m_axi_arid,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [63:0]           m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  err_overrun
);

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [31:0]      addr_arr [NUM_REQ];
  logic [LEN_W-1:0] len_arr  [NUM_REQ];

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] win_idx;
  logic             any_valid;
  logic [TAG_W:0]   cand;

  ar_state_t        state;
  ar_state_t        state_nxt;
  logic             grant;
  logic             fifo_push;

  logic [31:0]      ar_addr;
  logic [LEN_W-1:0] ar_len;
  logic [TAG_W-1:0] ar_id;

  logic [TAG_W-1:0] head_tag;
  logic [LEN_W-1:0] head_len;
  logic             tag_empty;
  logic             tag_full;
  logic             len_empty;
  logic             len_full;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  logic             r_hs;

  logic [LEN_W-1:0] beat_cnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*32 +: 32];
      len_arr[i]  = req_len[i*4 +: 4];
    end
  end

  // Scan from the highest offset down so the candidate nearest rr_ptr wins.
  always_comb begin
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (TAG_W + 1)'(i);
      if (cand >= (TAG_W + 1)'(NUM_REQ)) begin
        cand = cand - (TAG_W + 1)'(NUM_REQ);
      end
      if (req_valid[cand[TAG_W-1:0]]) begin
        win_idx   = cand[TAG_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign fifo_empty = tag_empty || len_empty;
  assign fifo_full  = tag_full || len_full;

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      state <= AR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A full FIFO that is retiring a burst this cycle already has room for the next AR,
  // so the following request is latched in the same cycle as the final rlast.
  always_comb begin
    state_nxt     = state;
    grant         = 1'b0;
    fifo_push     = 1'b0;
    m_axi_arvalid = 1'b0;
    case (state)
      AR_IDLE: begin
        if (!m_axi_rst && any_valid && (!fifo_full || fifo_pop)) begin
          grant     = 1'b1;
          state_nxt = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          fifo_push = 1'b1;
          state_nxt = AR_IDLE;
        end
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    req_ready          = '0;
    req_ready[win_idx] = grant;
  end

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      rr_ptr  <= '0;
      ar_addr <= '0;
      ar_len  <= '0;
      ar_id   <= '0;
    end else if (grant) begin
      rr_ptr  <= (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      ar_addr <= addr_arr[win_idx];
      ar_len  <= len_arr[win_idx];
      ar_id   <= win_idx;
    end
  end

  assign m_axi_araddr  = ar_addr;
  assign m_axi_arlen   = ar_len;
  assign m_axi_arid    = {{(ARID_W - TAG_W){1'b0}}, ar_id};
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;

  // Owner index of each outstanding burst.
  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .m_axi_clk (m_axi_clk),
    .m_axi_rst (m_axi_rst),
    .push      (fifo_push),
    .push_data (ar_id),
    .pop       (fifo_pop),
    .head      (head_tag),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Length shadow of the same bursts, used to check where rlast lands.
  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .m_axi_clk (m_axi_clk),
    .m_axi_rst (m_axi_rst),
    .push      (fifo_push),
    .push_data (ar_len),
    .pop       (fifo_pop),
    .head      (head_len),
    .empty     (len_empty),
    .full      (len_full)
  );

  always_comb begin
    rsp_valid    = '0;
    m_axi_rready = 1'b0;
    if (!fifo_empty) begin
      rsp_valid[head_tag] = m_axi_rvalid;
      m_axi_rready        = rsp_ready[head_tag];
    end
  end

  assign rsp_data = m_axi_rdata;
  assign rsp_last = m_axi_rlast;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign fifo_pop = r_hs && m_axi_rlast;

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (m_axi_rvalid && fifo_empty) begin
        err_overrun <= 1'b1;
      end
      if (r_hs) begin
        if (m_axi_rlast != (beat_cnt == head_len)) begin
          err_overrun <= 1'b1;
        end
        beat_cnt <= m_axi_rlast ? '0 : beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (4 requesters, 8 outstanding).
// A behavioural AXI slave returns beats in AR order with data = {id, addr + 8*beat}.
module tb_axi_rd_arbiter;

  localparam int NR = 4;
  localparam int OS = 8;

  logic           m_axi_clk = 1'b0;
  logic           m_axi_rst;
  logic [NR-1:0]  req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR*4-1:0]  req_len;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  rsp_valid;
  logic [63:0]    rsp_data;
  logic           rsp_last;
  logic [NR-1:0]  rsp_ready;
  logic           m_axi_arvalid;
  logic           m_axi_arready;
  logic [31:0]    m_axi_araddr;
  logic [3:0]     m_axi_arlen;
  logic [5:0]     m_axi_arid;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_rvalid;
  logic           m_axi_rready;
  logic [63:0]    m_axi_rdata;
  logic           m_axi_rlast;
  logic           err_overrun;

  always #5 m_axi_clk = ~m_axi_clk;

  axi_rd_arbiter #(
    .NUM_REQ     (NR),
    .OUTSTANDING (OS)
  ) dut (
    .m_axi_clk     (m_axi_clk),
    .m_axi_rst     (m_axi_rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_ready     (rsp_ready),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arid    (m_axi_arid),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .err_overrun   (err_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic r_en;
  logic force_rv;

  logic [31:0] sl_addr [$];
  logic [3:0]  sl_len  [$];
  logic [5:0]  sl_id   [$];
  int          beat;

  int          grant_q  [$];
  int          ar_cyc_q [$];
  logic [68:0] rx_q     [$];
  int          first_last_cyc = -1;

  always @(posedge m_axi_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] exp_beat(input int idx, input logic [31:0] a,
                                           input int b, input int len);
    return {4'(1 << idx), (b == len), 32'(idx), a + 32'(b * 8)};
  endfunction

  // Slave and monitor: handshakes are sampled at the falling edge (they complete on
  // the following rising edge), slave outputs change 1 time unit after the rising edge.
  initial begin
    logic ar_hs;
    logic r_hs;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rdata  = '0;
    beat         = 0;
    forever begin
      @(negedge m_axi_clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (!m_axi_rst) begin
        for (int i = 0; i < NR; i++) begin
          if (req_ready[i]) grant_q.push_back(i);
        end
        if (ar_hs) ar_cyc_q.push_back(cyc);
        if (r_hs) begin
          rx_q.push_back({rsp_valid, rsp_last, rsp_data});
          if (m_axi_rlast && first_last_cyc < 0) first_last_cyc = cyc;
        end
      end
      @(posedge m_axi_clk);
      #1;
      if (m_axi_rst) begin
        sl_addr.delete();
        sl_len.delete();
        sl_id.delete();
        beat = 0;
      end else begin
        if (ar_hs) begin
          sl_addr.push_back(m_axi_araddr);
          sl_len.push_back(m_axi_arlen);
          sl_id.push_back(m_axi_arid);
        end
        if (r_hs && sl_addr.size() > 0) begin
          if (beat == int'(sl_len[0])) begin
            void'(sl_addr.pop_front());
            void'(sl_len.pop_front());
            void'(sl_id.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
      end
      if (force_rv) begin
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        m_axi_rdata  = 64'hdead_beef_dead_beef;
      end else if (!m_axi_rst && r_en && sl_addr.size() > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = (beat == int'(sl_len[0]));
        m_axi_rdata  = {32'(sl_id[0]), sl_addr[0] + 32'(beat * 8)};
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rdata  = '0;
      end
    end
  end

  task automatic step();
    @(posedge m_axi_clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    m_axi_rst     = 1'b1;
    req_valid     = '0;
    rsp_ready     = '1;
    m_axi_arready = 1'b1;
    r_en          = 1'b1;
    force_rv      = 1'b0;
    step();
    step();
    grant_q.delete();
    ar_cyc_q.delete();
    rx_q.delete();
    first_last_cyc = -1;
    m_axi_rst = 1'b0;
  endtask

  task automatic send(input int idx, input logic [31:0] a, input logic [3:0] l);
    logic got;
    got = 1'b0;
    req_addr[idx*32 +: 32] = a;
    req_len[idx*4 +: 4]    = l;
    req_valid[idx]         = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge m_axi_clk);
      got = req_ready[idx];
      step();
    end
    req_valid[idx] = 1'b0;
    chk("send_grant", got, 1'b1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (rx_q.size() >= n) break;
      step();
    end
    chk(tag, rx_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int hb;
    m_axi_rst     = 1'b1;
    req_valid     = 4'b0001;
    req_addr      = '0;
    req_len       = '0;
    rsp_ready     = '1;
    m_axi_arready = 1'b1;
    r_en          = 1'b1;
    force_rv      = 1'b1;

    // Reset state with a pending request and a stray rvalid
    step();
    step();
    @(negedge m_axi_clk);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_err", err_overrun, 1'b0);

    // Single request: latency, AR fields, 4 beats to requester 0
    do_reset();
    req_addr[31:0] = 32'h1000;
    req_len[3:0]   = 4'd3;
    req_valid      = 4'b0001;
    @(negedge m_axi_clk);
    chk("t1_req_ready", req_ready, 4'b0001);
    chk("t1_arvalid_early", m_axi_arvalid, 1'b0);
    step();
    req_valid = '0;
    @(negedge m_axi_clk);
    chk("t1_arvalid", m_axi_arvalid, 1'b1);
    chk("t1_araddr", m_axi_araddr, 32'h1000);
    chk("t1_arlen", m_axi_arlen, 4'd3);
    chk("t1_arid", m_axi_arid, 6'd0);
    chk("t1_arsize", m_axi_arsize, 3'd3);
    chk("t1_arburst", m_axi_arburst, 2'd1);
    wait_rx(4, "t1_beat_count");
    for (int b = 0; b < 4; b++) begin
      chk("t1_beat", (b < rx_q.size()) ? rx_q[b] : '1, exp_beat(0, 32'h1000, b, 3));
    end

    // All requesters valid: round-robin 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*32 +: 32] = 32'h0001_0000 + 32'(i * 32'h100);
      req_len[i*4 +: 4]    = 4'd0;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 100; k++) begin
      step();
      if (grant_q.size() >= 8) break;
    end
    req_valid = '0;
    wait_rx(8, "t2_beat_count");
    chk("t2_grant_count", grant_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_order", (k < grant_q.size()) ? grant_q[k] : -1, k % 4);
      chk("t2_beat", (k < rx_q.size()) ? rx_q[k] : '1,
          exp_beat(k % 4, 32'h0001_0000 + 32'((k % 4) * 32'h100), 0, 0));
    end

    // Outstanding limit: 8 ARs, 9th follows the first rlast handshake by one cycle
    do_reset();
    r_en           = 1'b0;
    req_addr[31:0] = 32'h4000;
    req_len[3:0]   = 4'd1;
    req_valid      = 4'b0001;
    repeat (30) step();
    chk("t3_ar_count", ar_cyc_q.size(), 8);
    chk("t3_ar_rate", (ar_cyc_q.size() > 1) ? ar_cyc_q[1] - ar_cyc_q[0] : -1, 2);
    @(negedge m_axi_clk);
    chk("t3_blocked", m_axi_arvalid, 1'b0);
    chk("t3_no_grant", req_ready, 4'b0000);
    step();
    r_en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (ar_cyc_q.size() >= 9) break;
    end
    req_valid = '0;
    chk("t3_ar9_cycle", (ar_cyc_q.size() >= 9) ? ar_cyc_q[8] : -1, first_last_cyc + 1);

    // Back-pressure from requester 1 mid-burst; order versus reference list
    do_reset();
    send(1, 32'h2000, 4'd7);
    send(2, 32'h3000, 4'd1);
    for (int k = 0; k < 50; k++) begin
      if (rx_q.size() >= 2) break;
      step();
    end
    rsp_ready[1] = 1'b0;
    hb = rx_q.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge m_axi_clk);
      chk("t4_rready_held", m_axi_rready, 1'b0);
      chk("t4_data_held", rsp_data, {32'd1, 32'h2000 + 32'(hb * 8)});
      chk("t4_owner_held", rsp_valid, 4'b0010);
      step();
    end
    rsp_ready = '1;
    wait_rx(10, "t4_beat_count");
    for (int b = 0; b < 8; b++) begin
      chk("t4_beat_r1", (b < rx_q.size()) ? rx_q[b] : '1, exp_beat(1, 32'h2000, b, 7));
    end
    for (int b = 0; b < 2; b++) begin
      chk("t4_beat_r2", (8 + b < rx_q.size()) ? rx_q[8 + b] : '1, exp_beat(2, 32'h3000, b, 1));
    end

    // Reset with bursts outstanding and an AR stalled on arready
    do_reset();
    r_en = 1'b0;
    send(2, 32'h5000, 4'd3);
    send(3, 32'h6000, 4'd3);
    send(1, 32'h7000, 4'd3);
    step();
    step();
    chk("t5_outstanding", ar_cyc_q.size(), 3);
    m_axi_arready = 1'b0;
    send(0, 32'h8000, 4'd0);
    @(negedge m_axi_clk);
    chk("t5_arvalid_pre", m_axi_arvalid, 1'b1);
    step();
    m_axi_rst = 1'b1;
    req_valid = 4'b1000;
    force_rv  = 1'b1;
    @(negedge m_axi_clk);
    chk("t5_arvalid_rst", m_axi_arvalid, 1'b0);
    chk("t5_req_ready_rst", req_ready, 4'b0000);
    step();
    @(negedge m_axi_clk);
    chk("t5_rsp_valid_rst", rsp_valid, 4'b0000);
    chk("t5_rready_rst", m_axi_rready, 1'b0);
    chk("t5_err_rst", err_overrun, 1'b0);
    step();
    force_rv = 1'b0;
    step();
    m_axi_rst     = 1'b0;
    req_valid     = 4'b1111;
    m_axi_arready = 1'b1;
    @(negedge m_axi_clk);
    chk("t5_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;

    // Stray beat with nothing outstanding sets the sticky error
    do_reset();
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    @(negedge m_axi_clk);
    chk("t6_rsp_valid", rsp_valid, 4'b0000);
    chk("t6_rready", m_axi_rready, 1'b0);
    chk("t6_err_before", err_overrun, 1'b0);
    step();
    @(negedge m_axi_clk);
    chk("t6_err_set", err_overrun, 1'b1);
    repeat (5) step();
    @(negedge m_axi_clk);
    chk("t6_err_sticky", err_overrun, 1'b1);
    do_reset();
    @(negedge m_axi_clk);
    chk("t6_err_cleared", err_overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
